ext_pc_ctrl: RTL and testbench
==============================

// Module: ext_pc_ctrl
// PURPOSE
//  Drives the core's external PC-redirect port (extern_pc / extern_pc_en) of
//  top_module_looper. This is the producer end of the port.
//  - After reset it issues one boot redirect to BOOT_PC.
//  - It then accepts host redirect requests over a valid/ready handshake.
//  - It holds each request until the core is not flushing (mis-prediction
//    recovery), then pulses extern_pc_en with the requested PC.
//  Sits between the host/debug interface and the core fetch stage.
// PARAMETERS
//  PC_W      16      width of PC bus
//  BOOT_PC   16'h0   PC driven by the post-reset boot redirect
//  BOOT_DLY  4       idle cycles after reset release before boot redirect (0 allowed)
//  HOLD_CYC  2       cycles extern_pc_en stays high per redirect (0 treated as 1)
// PORTS
//  clk           in   1     clock, rising edge
//  rst_n         in   1     asynchronous, active-low reset
//  host_pc       in   PC_W  requested redirect PC
//  host_vld      in   1     host request valid
//  host_rdy      out  1     block can accept request
//  core_flush    in   1     core mis-prediction recovery in progress (mis_pred_ROB_out)
//  extern_pc     out  PC_W  PC to core
//  extern_pc_en  out  1     redirect strobe to core
//  busy          out  1     high in any state except IDLE
//  redir_cnt     out  8     count of completed host redirects, saturating
// BEHAVIOUR
//  Clocking, reset and output timing
//  - All outputs are registered. No combinational path from any input to any output.
//  - Reset values: extern_pc=BOOT_PC, extern_pc_en=0, host_rdy=0, busy=1,
//    redir_cnt=0, state=BOOT_WAIT, hold/delay counters=0.
//  FSM states: BOOT_WAIT, WAIT_QUIET, DRIVE, IDLE.
//  - BOOT_WAIT: delay counter counts BOOT_DLY cycles after reset release.
//    -> DRIVE on the terminal count, with target=BOOT_PC and boot flag set.
//    -> If BOOT_DLY=0, DRIVE is entered at the first edge after reset release.
//  - IDLE: host_rdy=1, busy=0.
//    -> Accept occurs on the edge where host_vld & host_rdy. host_pc is captured
//       into target and the next state is WAIT_QUIET. host_rdy falls at the same edge.
//  - WAIT_QUIET: holds while core_flush=1.
//    -> At the first edge with core_flush=0: DRIVE, extern_pc<=target, extern_pc_en<=1.
//    -> Minimum latency: accept at edge k, extern_pc_en high from edge k+1
//       through edge k+1+HOLD_CYC.
//  - DRIVE: extern_pc_en stays 1 for exactly max(HOLD_CYC,1) cycles;
//    extern_pc is stable throughout.
//    -> Then extern_pc_en<=0 and state -> IDLE.
//    -> redir_cnt increments by 1 at DRIVE exit for host redirects only
//       (boot excluded). It saturates at 8'hFF.
//  - The boot redirect ignores core_flush.
//  - extern_pc retains the last driven value after the pulse ends.
//  Boundary conditions
//  - core_flush rising during DRIVE is ignored; the pulse completes at full length.
//  - host_vld while host_rdy=0 has no effect. The host must hold its request
//    (standard valid/ready).
//  - host_pc changing after accept does not affect target.
//  - Back-to-back requests: the next accept is possible at the first edge
//    after IDLE is re-entered.
//  - Reset asserted in any state (including mid-DRIVE) forces the reset values
//    immediately: the pulse is aborted, any pending request is dropped, and the
//    FSM restarts the boot sequence.
//  - Illegal state encodings recover to IDLE with extern_pc_en=0.
// TESTING
//  - Boot: release rst_n at t0, BOOT_DLY=4, BOOT_PC=16'h0010 ->
//    extern_pc_en high for exactly 2 cycles starting at the 5th edge after
//    release; extern_pc=16'h0010; redir_cnt=0; then host_rdy=1.
//  - Host redirect, no flush: host_pc=16'h1234, host_vld for 1 cycle in IDLE ->
//    host_rdy drops next edge; extern_pc=16'h1234 with en high for 2 cycles
//    starting 1 edge after accept; redir_cnt=1.
//  - Flush stall: accept 16'h00A0 while core_flush=1 for 6 cycles ->
//    no strobe during flush; strobe begins at the first edge with flush low;
//    busy=1 throughout.
//  - Flush during DRIVE: raise core_flush in the 1st DRIVE cycle ->
//    pulse still 2 cycles; state returns to IDLE.
//  - Reset mid-DRIVE: assert rst_n=0 while extern_pc_en=1 ->
//    extern_pc_en=0 and extern_pc=BOOT_PC immediately; boot sequence repeats
//    after release.
//  - Saturation: 260 back-to-back host redirects -> redir_cnt stops at 8'hFF;
//    HOLD_CYC=0 build -> 1-cycle strobes.

Source files
------------

// File: rtl/ext_pc_ctrl.sv
// Producer for the core's external PC-redirect port: one boot redirect after reset,
// then host valid/ready requests, each deferred until the core has finished flushing.
module ext_pc_ctrl #(
    parameter int                PC_W     = 16,
    parameter logic [PC_W-1:0]   BOOT_PC  = '0,
    parameter int                BOOT_DLY = 4,
    parameter int                HOLD_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] host_pc,
    input  logic            host_vld,
    output logic            host_rdy,
    input  logic            core_flush,
    output logic [PC_W-1:0] extern_pc,
    output logic            extern_pc_en,
    output logic            busy,
    output logic [7:0]      redir_cnt
);

    localparam int HOLD_EFF = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
    localparam int DLY_W    = (BOOT_DLY < 2) ? 1 : $clog2(BOOT_DLY + 1);
    localparam int HLD_W    = (HOLD_EFF < 2) ? 1 : $clog2(HOLD_EFF);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(BOOT_DLY);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_EFF - 1);

    typedef enum logic [1:0] {
        BOOT_WAIT  = 2'd0,
        WAIT_QUIET = 2'd1,
        DRIVE      = 2'd2,
        IDLE       = 2'd3
    } state_t;

    state_t          state_q,  state_d;
    logic [DLY_W-1:0] dly_q,   dly_d;
    logic [HLD_W-1:0] hold_q,  hold_d;
    logic [PC_W-1:0] target_q, target_d;
    logic            boot_q,   boot_d;
    logic [PC_W-1:0] pc_q,     pc_d;
    logic            en_q,     en_d;
    logic            rdy_q,    rdy_d;
    logic            busy_q,   busy_d;
    logic [7:0]      cnt_q,    cnt_d;

    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        hold_d   = hold_q;
        target_d = target_q;
        boot_d   = boot_q;
        pc_d     = pc_q;
        en_d     = en_q;
        rdy_d    = rdy_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        case (state_q)
            BOOT_WAIT: begin
                // The boot redirect is not gated by core_flush.
                if (dly_q == DLY_LAST) begin
                    state_d  = DRIVE;
                    target_d = BOOT_PC;
                    boot_d   = 1'b1;
                    pc_d     = BOOT_PC;
                    en_d     = 1'b1;
                    hold_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            IDLE: begin
                if (host_vld && rdy_q) begin
                    state_d  = WAIT_QUIET;
                    target_d = host_pc;
                    boot_d   = 1'b0;
                    rdy_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            WAIT_QUIET: begin
                if (!core_flush) begin
                    state_d = DRIVE;
                    pc_d    = target_q;
                    en_d    = 1'b1;
                    hold_d  = '0;
                end
            end
            DRIVE: begin
                // Pulse length is fixed once started; core_flush is not consulted here.
                if (hold_q == HLD_LAST) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                    if (!boot_q && (cnt_q != 8'hFF)) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT_WAIT;
            dly_q    <= '0;
            hold_q   <= '0;
            target_q <= BOOT_PC;
            boot_q   <= 1'b1;
            pc_q     <= BOOT_PC;
            en_q     <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            hold_q   <= hold_d;
            target_q <= target_d;
            boot_q   <= boot_d;
            pc_q     <= pc_d;
            en_q     <= en_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign host_rdy     = rdy_q;
    assign extern_pc    = pc_q;
    assign extern_pc_en = en_q;
    assign busy         = busy_q;
    assign redir_cnt    = cnt_q;

endmodule

// File: tb/tb_ext_pc_ctrl.sv
// Directed bench for ext_pc_ctrl: a scoreboard queue of expected redirect PCs is
// checked by a pulse monitor, alongside inline timing/state checks.
module tb_ext_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a_hpc, b_hpc;
    logic        a_vld, b_vld, a_flush, b_flush;
    logic        a_rdy, b_rdy, a_en, b_en, a_busy, b_busy;
    logic [15:0] a_pc, b_pc;
    logic [7:0]  a_cnt, b_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    ext_pc_ctrl #(.PC_W(16), .BOOT_PC(16'h0010), .BOOT_DLY(4), .HOLD_CYC(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .host_pc(a_hpc), .host_vld(a_vld), .host_rdy(a_rdy),
        .core_flush(a_flush), .extern_pc(a_pc), .extern_pc_en(a_en), .busy(a_busy),
        .redir_cnt(a_cnt)
    );

    ext_pc_ctrl #(.PC_W(16), .BOOT_PC(16'h0B00), .BOOT_DLY(0), .HOLD_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .host_pc(b_hpc), .host_vld(b_vld), .host_rdy(b_rdy),
        .core_flush(b_flush), .extern_pc(b_pc), .extern_pc_en(b_en), .busy(b_busy),
        .redir_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse monitor on dut_a: pops the expected PC at each strobe start.
    logic        in_pulse = 1'b0;
    int          plen = 0;
    logic [15:0] pc_at = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_pulse = 1'b0;
        end else if (a_en && !in_pulse) begin
            in_pulse = 1'b1;
            plen     = 1;
            pc_at    = a_pc;
            if (exp_q.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
            else chk("sb_pc", a_pc, exp_q.pop_front());
        end else if (a_en && in_pulse) begin
            plen++;
            chk("pc_stable", a_pc, pc_at);
        end else if (!a_en && in_pulse) begin
            in_pulse = 1'b0;
            chk("pulse_len", plen, 2);
        end
    end

    task automatic boot_a_check(input string tag);
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk({tag, "_wait_en"}, a_en, 1'b0);
        end
        tick();
        chk({tag, "_en_on"}, a_en, 1'b1);
        chk({tag, "_pc"}, a_pc, 16'h0010);
        chk({tag, "_busy"}, a_busy, 1'b1);
        tick();
        chk({tag, "_en_hold"}, a_en, 1'b1);
        tick();
        chk({tag, "_en_off"}, a_en, 1'b0);
        chk({tag, "_rdy"}, a_rdy, 1'b1);
        chk({tag, "_idle"}, a_busy, 1'b0);
        chk({tag, "_cnt"}, a_cnt, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        a_vld = 1'b0; a_hpc = '0; a_flush = 1'b0;
        b_vld = 1'b0; b_hpc = '0; b_flush = 1'b0;
        repeat (3) tick();
        chk("rst_en", a_en, 1'b0);
        chk("rst_pc", a_pc, 16'h0010);
        chk("rst_rdy", a_rdy, 1'b0);
        chk("rst_busy", a_busy, 1'b1);
        chk("rst_cnt", a_cnt, 8'd0);
        chk("b_rst_pc", b_pc, 16'h0B00);

        // Boot of both instances; dut_b has zero delay and single-cycle strobes.
        exp_q.push_back(16'h0010);
        rst_n = 1'b1;
        tick();
        chk("boot_e1_en", a_en, 1'b0);
        chk("b_boot_en", b_en, 1'b1);
        chk("b_boot_pc", b_pc, 16'h0B00);
        tick();
        chk("boot_e2_en", a_en, 1'b0);
        chk("b_boot_off", b_en, 1'b0);
        chk("b_boot_rdy", b_rdy, 1'b1);
        tick();
        chk("boot_e3_en", a_en, 1'b0);
        tick();
        chk("boot_e4_en", a_en, 1'b0);
        tick();
        chk("boot_e5_en", a_en, 1'b1);
        chk("boot_pc", a_pc, 16'h0010);
        tick();
        chk("boot_e6_en", a_en, 1'b1);
        tick();
        chk("boot_e7_en", a_en, 1'b0);
        chk("boot_rdy", a_rdy, 1'b1);
        chk("boot_cnt", a_cnt, 8'd0);

        // Host redirect, no flush; host_pc changes after accept.
        a_vld = 1'b1; a_hpc = 16'h1234; exp_q.push_back(16'h1234);
        tick();
        chk("h1_rdy_drop", a_rdy, 1'b0);
        chk("h1_busy", a_busy, 1'b1);
        chk("h1_no_en", a_en, 1'b0);
        a_vld = 1'b0; a_hpc = 16'hFFFF;
        tick();
        chk("h1_en", a_en, 1'b1);
        chk("h1_pc", a_pc, 16'h1234);
        tick();
        chk("h1_en2", a_en, 1'b1);
        tick();
        chk("h1_off", a_en, 1'b0);
        chk("h1_cnt", a_cnt, 8'd1);
        chk("h1_rdy", a_rdy, 1'b1);
        chk("h1_keep_pc", a_pc, 16'h1234);

        // Flush stall for 6 cycles.
        a_flush = 1'b1; a_vld = 1'b1; a_hpc = 16'h00A0; exp_q.push_back(16'h00A0);
        tick();
        a_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fl_no_en", a_en, 1'b0);
            chk("fl_busy", a_busy, 1'b1);
        end
        a_flush = 1'b0;
        tick();
        chk("fl_en", a_en, 1'b1);
        chk("fl_pc", a_pc, 16'h00A0);
        tick();
        tick();
        chk("fl_off", a_en, 1'b0);
        chk("fl_cnt", a_cnt, 8'd2);

        // Flush raised during DRIVE is ignored.
        a_vld = 1'b1; a_hpc = 16'h0BEE; exp_q.push_back(16'h0BEE);
        tick();
        a_vld = 1'b0;
        tick();
        chk("fd_en", a_en, 1'b1);
        a_flush = 1'b1;
        tick();
        chk("fd_en2", a_en, 1'b1);
        tick();
        chk("fd_off", a_en, 1'b0);
        chk("fd_rdy", a_rdy, 1'b1);
        chk("fd_idle", a_busy, 1'b0);
        chk("fd_cnt", a_cnt, 8'd3);
        a_flush = 1'b0;

        // Held valid while not ready, then back-to-back accept on IDLE re-entry.
        a_vld = 1'b1; a_hpc = 16'h0C0C; exp_q.push_back(16'h0C0C);
        tick();
        chk("bb_rdy0", a_rdy, 1'b0);
        a_hpc = 16'hDEAD;
        tick();
        tick();
        tick();
        chk("bb_rdy1", a_rdy, 1'b1);
        chk("bb_cnt1", a_cnt, 8'd4);
        exp_q.push_back(16'hDEAD);
        tick();
        chk("bb_accept2", a_rdy, 1'b0);
        a_vld = 1'b0;
        tick();
        chk("bb_en", a_en, 1'b1);
        chk("bb_pc", a_pc, 16'hDEAD);
        tick();
        tick();
        chk("bb_off", a_en, 1'b0);
        chk("bb_cnt2", a_cnt, 8'd5);

        // dut_b host redirect: single-cycle strobe.
        b_vld = 1'b1; b_hpc = 16'h2222;
        tick();
        chk("b_rdy_drop", b_rdy, 1'b0);
        b_vld = 1'b0;
        tick();
        chk("b_en", b_en, 1'b1);
        chk("b_pc", b_pc, 16'h2222);
        tick();
        chk("b_off", b_en, 1'b0);
        chk("b_rdy", b_rdy, 1'b1);
        chk("b_cnt", b_cnt, 8'd1);

        // Reset mid-DRIVE.
        a_vld = 1'b1; a_hpc = 16'h0777; exp_q.push_back(16'h0777);
        tick();
        a_vld = 1'b0;
        tick();
        chk("rd_en", a_en, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rd_en_abort", a_en, 1'b0);
        chk("rd_pc", a_pc, 16'h0010);
        chk("rd_rdy", a_rdy, 1'b0);
        chk("rd_busy", a_busy, 1'b1);
        chk("rd_cnt", a_cnt, 8'd0);
        tick();
        tick();
        exp_q.push_back(16'h0010);
        rst_n = 1'b1;
        boot_a_check("reboot");

        // Saturation of redir_cnt.
        for (int i = 0; i < 260; i++) begin
            a_vld = 1'b1;
            a_hpc = 16'h4000 + 16'(i);
            exp_q.push_back(16'h4000 + 16'(i));
            tick();
            a_vld = 1'b0;
            tick();
            tick();
            tick();
            chk("sat_cnt", a_cnt, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
        end
        chk("sat_final", a_cnt, 8'hFF);

        repeat (2) tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
